stopwatch_ctrl: RTL and testbench

Sequencing controller for the 00–99 BCD counter and its 7-segment display path. Takes three raw push-buttons (start/stop, clear, lap), debounces them, and runs a four-state FSM. The FSM issues single-cycle count-advance and clear pulses to the counter and a hold level to the display latch, replacing the derived slow clock with clock-enable pulses in the `clk` domain.

---
 rtl/stopwatch_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- button conditioning and run/pause/lap sequencing for the
// 00-99 BCD counter. All counter/display control is issued as single-cycle
// enables in the clk domain; there is no derived slow clock.
//
// Optional feature: define STOPWATCH_AUTOSTOP_EN to make a tick that lands
// while the counter shows 99 pause the stopwatch instead of wrapping to 00.

module stopwatch_ctrl #(
  parameter int TICK_DIV        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic       at_99,
  output logic       count_tick,
  output logic       count_clr,
  output logic       disp_hold,
  output logic [1:0] state,
  output logic       running
);

  localparam int NUM_BTN = 3;
  localparam int B_START = 0;
  localparam int B_CLEAR = 1;
  localparam int B_LAP   = 2;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // press events after priority resolution: at most one field is set
  typedef struct packed {
    logic clear;
    logic start;
    logic lap;
  } btn_ev_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_press;
  btn_ev_t            ev;

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               was_running, now_running;
  logic               tick_cond, autostop;
  logic               tick_d, clr_d, hold_d, run_d;

  assign btn_raw = {btn_lap, btn_clear, btn_start};

  // ---------------------------------------------------------------------
  // Per-button lane: 2-FF synchroniser, debouncer, press-edge pulse
  // ---------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      logic [1:0]    sync_pipe;
      logic          level;
      logic [DW-1:0] cnt;
      logic          press_r;
      logic          differ, flip;

      assign differ       = sync_pipe[1] ^ level;
      assign flip         = differ && (cnt == DB_LAST);
      assign btn_press[i] = press_r;

      // synchronise the raw asynchronous button; sync_pipe[1] is safe to use
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_pipe <= 2'b00;
        else       sync_pipe <= {sync_pipe[0], btn_raw[i]};
      end

      // level flips after DEBOUNCE_CYCLES consecutive disagreeing samples;
      // only the rising flip is reported, as a one-cycle press
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          level   <= 1'b0;
          cnt     <= '0;
          press_r <= 1'b0;
        end else begin
          press_r <= flip & ~level;
          if (flip) begin
            level <= ~level;
            cnt   <= '0;
          end else if (differ) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
        end
      end
    end
  endgenerate

  // clear beats start beats lap; losers in the same cycle are dropped
  assign ev.clear = btn_press[B_CLEAR];
  assign ev.start = btn_press[B_START] & ~btn_press[B_CLEAR];
  assign ev.lap   = btn_press[B_LAP] & ~btn_press[B_START] & ~btn_press[B_CLEAR];

  assign was_running = (state_q == RUN) || (state_q == LAP);
  assign now_running = (state_d == RUN) || (state_d == LAP);
  assign tick_cond   = was_running && (presc_q == PRESC_LAST);

`ifdef STOPWATCH_AUTOSTOP_EN
  assign autostop = tick_cond & at_99;
`else
  // at_99 only matters when auto-stop is built in; the counter wraps itself
  logic at_99_unused;
  assign at_99_unused = at_99;
  assign autostop     = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state decode from the resolved press event
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ev.clear)      state_d = IDLE;
        else if (ev.start) state_d = RUN;
      end
      RUN: begin
        if (ev.clear)                 state_d = RUN;
        else if (ev.start || autostop) state_d = PAUSE;
        else if (ev.lap)              state_d = LAP;
      end
      PAUSE: begin
        if (ev.clear)      state_d = IDLE;
        else if (ev.start) state_d = RUN;
      end
      LAP: begin
        if (ev.clear)                 state_d = IDLE;
        else if (ev.start || autostop) state_d = PAUSE;
        else if (ev.lap)              state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // output and prescaler decode; values are registered below
  always_comb begin
    clr_d  = ev.clear;
    tick_d = tick_cond & ~ev.clear & ~autostop;
    hold_d = (state_d == LAP);
    run_d  = now_running;

    // The prescaler freezes on the edge that leaves RUN/LAP, so a pause
    // resumes from exactly the value seen when the press was taken.
    presc_d = presc_q;
    if (state_d == IDLE || ev.clear)  presc_d = '0;
    else if (tick_cond)               presc_d = '0;
    else if (was_running && now_running) presc_d = presc_q + 1'b1;
  end

  // registered outputs and prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      count_tick <= 1'b0;
      count_clr  <= 1'b0;
      disp_hold  <= 1'b0;
      running    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      count_tick <= tick_d;
      count_clr  <= clr_d;
      disp_hold  <= hold_d;
      running    <= run_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (TICK_DIV=4, DEBOUNCE_CYCLES=3).
// A behavioural model predicts every tick, clear and state change; a
// separate monitor pops and compares whenever the DUT shows one.

module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap   = 1'b0;
  logic       at_99     = 1'b0;
  logic       count_tick, count_clr, disp_hold, running;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_lap    (btn_lap),
    .at_99      (at_99),
    .count_tick (count_tick),
    .count_clr  (count_clr),
    .disp_hold  (disp_hold),
    .state      (state),
    .running    (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd99    = 1'b0;

  typedef struct {
    int unsigned cyc;
    logic        tick;
    logic        clr;
    logic [1:0]  st;
    logic        hold;
    logic        run;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;

  // reference model: states 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
  int          m_st    = 0;
  int          m_phase = 0;   // running cycles since last tick/restart
  logic [15:0] m_hist[3];     // raw samples, bit j = sample j edges ago
  logic        m_deb[3];
  logic        m_pend[3];     // press seen this edge, acted on next edge

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st    = 0;
    m_phase = 0;
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = '0;
      m_deb[b]  = 1'b0;
      m_pend[b] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic       e_clr, e_st, e_lap, tick, stop99, was_run, now_run, all_diff;
    logic [2:0] raw;
    int         nxt;
    exp_t       e;

    e_clr   = m_pend[1];
    e_st    = m_pend[0] && !e_clr;
    e_lap   = m_pend[2] && !e_clr && !e_st;
    was_run = (m_st == 1 || m_st == 3);
    tick    = was_run && (m_phase == TD - 1);
    stop99  = 1'b0;
`ifdef STOPWATCH_AUTOSTOP_EN
    stop99  = tick && at_99;
`endif

    nxt = m_st;
    if (e_clr)       nxt = (m_st == 1) ? 1 : 0;
    else if (e_st)   nxt = (m_st == 0 || m_st == 2) ? 1 : 2;
    else if (stop99) nxt = 2;
    else if (e_lap)  nxt = (m_st == 1) ? 3 : ((m_st == 3) ? 1 : m_st);
    now_run = (nxt == 1 || nxt == 3);

    e.cyc  = cyc;
    e.tick = tick && !e_clr && !stop99;
    e.clr  = e_clr;
    e.st   = 2'(nxt);
    e.hold = (nxt == 3);
    e.run  = now_run;
    if (e.tick || e.clr || nxt != m_st) sb_q.push_back(e);

    if (nxt == 0 || e_clr)       m_phase = 0;
    else if (tick)               m_phase = 0;
    else if (was_run && now_run) m_phase = m_phase + 1;
    m_st = nxt;

    // debounced level flips once the last DB synchronised samples
    // (two edges old and older) all disagree with it
    raw = {btn_lap, btn_clear, btn_start};
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][14:0], raw[b]};
      all_diff  = 1'b1;
      for (int j = 2; j <= DB + 1; j++)
        if (m_hist[b][j] == m_deb[b]) all_diff = 1'b0;
      m_pend[b] = 1'b0;
      if (all_diff) begin
        m_pend[b] = !m_deb[b];
        m_deb[b]  = !m_deb[b];
      end
    end
  endtask

  // model runs on every active edge using the inputs present at that edge
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        model_reset();
        sb_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // monitor: any visible DUT activity consumes one expected record
  initial begin
    logic [1:0] prev_st;
    exp_t       e;
    prev_st = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_st = 2'b00;
      end else begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          e = sb_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL sb_missed: nothing seen, expected at cyc %0d tick=%0d clr=%0d st=%0d",
                   e.cyc, e.tick, e.clr, e.st);
        end
        if (count_tick || count_clr || state != prev_st) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: cyc %0d got tick=%0d clr=%0d st=%0d, expected no activity",
                     cyc, count_tick, count_clr, state);
          end else begin
            e = sb_q.pop_front();
            if (e.cyc != cyc || e.tick !== count_tick || e.clr !== count_clr ||
                e.st !== state || e.hold !== disp_hold || e.run !== running) begin
              n_fail++;
              $display("FAIL sb_event: got cyc=%0d tick=%0d clr=%0d st=%0d hold=%0d run=%0d expected cyc=%0d tick=%0d clr=%0d st=%0d hold=%0d run=%0d",
                       cyc, count_tick, count_clr, state, disp_hold, running,
                       e.cyc, e.tick, e.clr, e.st, e.hold, e.run);
            end
          end
        end
        prev_st = state;
      end
    end
  end

  task automatic cyc_wait(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (rnd99) at_99 = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic press(logic [2:0] m, int hold, int gap);
    {btn_lap, btn_clear, btn_start} = m;
    cyc_wait(hold);
    {btn_lap, btn_clear, btn_start} = 3'b000;
    cyc_wait(gap);
  endtask

  task automatic check_reset(string tag);
    #1;
    check({tag, "_tick"},  count_tick, 0);
    check({tag, "_clr"},   count_clr,  0);
    check({tag, "_hold"},  disp_hold,  0);
    check({tag, "_run"},   running,    0);
    check({tag, "_state"}, state,      0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    cyc_wait(2);
    check_reset("rst");
    reset = 1'b0;
    cyc_wait(3);

    // bounces shorter than the debounce window never register
    btn_start = 1'b1; cyc_wait(2);
    btn_start = 1'b0; cyc_wait(1);
    btn_start = 1'b1; cyc_wait(2);
    btn_start = 1'b0; cyc_wait(8);
    check("bounce_state", state, 0);

    press(3'b001, 5, 22);            // start, several ticks follow
    check("start_state", state, 1);
    press(3'b001, 5, 10);            // pause
    check("pause_state", state, 2);
    press(3'b001, 5, 14);            // resume
    check("resume_state", state, 1);
    press(3'b100, 5, 12);            // lap
    check("lap_hold", disp_hold, 1);
    check("lap_state", state, 3);
    press(3'b100, 5, 10);            // lap again -> run
    check("unlap_hold", disp_hold, 0);
    check("unlap_state", state, 1);
    press(3'b011, 5, 10);            // clear + start together in RUN
    check("clr_start_state", state, 1);

    at_99 = 1'b1; cyc_wait(6);       // a tick lands while showing 99
    at_99 = 1'b0; cyc_wait(4);
`ifdef STOPWATCH_AUTOSTOP_EN
    check("at99_state", state, 2);
`else
    check("at99_state", state, 1);
`endif

    // reset mid-operation with start held: needs a fresh debounce
    btn_start = 1'b1;
    reset = 1'b1;
    check_reset("midrst");
    cyc_wait(2);
    reset = 1'b0;
    cyc_wait(8);
    btn_start = 1'b0;
    cyc_wait(8);
    check("held_after_reset", state, 1);

    // randomized mix of presses, glitches, idles, at_99 and resets
    rnd99 = 1'b1;
    for (int it = 0; it < 220; it++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op < 5) begin
        cyc_wait($urandom_range(1, 8));
      end else if (op < 16) begin
        press(3'($urandom_range(1, 7)), $urandom_range(3, 7), $urandom_range(0, 8));
      end else if (op < 19) begin
        press(3'($urandom_range(1, 7)), $urandom_range(1, 2), $urandom_range(0, 4));
      end else begin
        reset = 1'b1;
        check_reset("rndrst");
        cyc_wait(2);
        reset = 1'b0;
        cyc_wait(1);
      end
    end

    rnd99 = 1'b0;
    at_99 = 1'b0;
    {btn_lap, btn_clear, btn_start} = 3'b000;
    cyc_wait(12);
    check("sb_drain", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
